// File: rtl/port_stats_collector_if.sv
// Result-strobe input and counter read port of the per-port statistics collector.
// The master side drives packet results, clear and read requests; the slave returns read data.
interface port_stats_collector_if #(
    parameter int ATTR_W = 135,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              pkt_valid;
    logic [ATTR_W-1:0] pkt_attributes;
    logic              clear_stats;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output pkt_valid, pkt_attributes, clear_stats, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  pkt_valid, pkt_attributes, clear_stats, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/port_stats_collector.sv
// Per-input-port packet/byte, per-protocol and unknown-port counters behind a registered read port.
// Latency: counters reflect a result two edges after pkt_valid; reads return one edge after rd_en.
// Backpressure: none; a result every cycle is absorbed without loss.
module port_stats_collector #(
    parameter int NUM_INPUT_QUEUES              = 8,
    parameter int NETWORK_PROTOCOL_COMBINATIONS = 4,
    parameter int PRTCL_ID_WIDTH                = 2,
    parameter int BYTES_COUNT_WIDTH             = 16,
    parameter int ATTRIBUTE_DATA_WIDTH          = 135,
    parameter int PKT_CNT_WIDTH                 = 32,
    parameter int BYTE_CNT_WIDTH                = 48
) (
    input logic                   clk,
    input logic                   reset,
    port_stats_collector_if.slave bus
);
    localparam int N         = NUM_INPUT_QUEUES;
    localparam int P         = NETWORK_PROTOCOL_COMBINATIONS;
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;
    localparam int BYTES_LSB = 104;
    localparam int PRTCL_LSB = BYTES_LSB + BYTES_COUNT_WIDTH + 5;
    localparam int PORT_LSB  = PRTCL_LSB + PRTCL_ID_WIDTH;

    logic [ATTRIBUTE_DATA_WIDTH-1:0] attr;
    assign attr = bus.pkt_attributes;

    logic                         s1_valid;
    logic [BYTES_COUNT_WIDTH-1:0] s1_bytes;
    logic [PRTCL_ID_WIDTH-1:0]    s1_prtcl;
    logic [N-1:0]                 s1_port;

    logic [PKT_CNT_WIDTH-1:0]  pkt_cnt   [N];
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt  [N];
    logic [PKT_CNT_WIDTH-1:0]  proto_cnt [P];
    logic [PKT_CNT_WIDTH-1:0]  unknown_cnt;

    logic [63:0] rd_mux;
    logic [63:0] rd_data_q;
    logic        rd_valid_q;

    logic             port_hit;
    logic [IDX_W-1:0] port_idx;

    // A port vector is a valid source only when exactly one bit is set.
    always_comb begin
        port_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (s1_port[i]) port_idx = i[IDX_W-1:0];
        end
        port_hit = (s1_port != '0) && ((s1_port & (s1_port - N'(1))) == '0);
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.rd_addr == 8'(i))     rd_mux = 64'(pkt_cnt[i]);
            if (bus.rd_addr == 8'(N + i)) rd_mux = 64'(byte_cnt[i]);
        end
        for (int j = 0; j < P; j++) begin
            if (bus.rd_addr == 8'(2 * N + j)) rd_mux = 64'(proto_cnt[j]);
        end
        if (bus.rd_addr == 8'(2 * N + P)) rd_mux = 64'(unknown_cnt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_bytes    <= '0;
            s1_prtcl    <= '0;
            s1_port     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            unknown_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                pkt_cnt[i]  <= '0;
                byte_cnt[i] <= '0;
            end
            for (int j = 0; j < P; j++) proto_cnt[j] <= '0;
        end else begin
            s1_valid <= bus.pkt_valid;
            if (bus.pkt_valid) begin
                s1_bytes <= attr[BYTES_LSB +: BYTES_COUNT_WIDTH];
                s1_prtcl <= attr[PRTCL_LSB +: PRTCL_ID_WIDTH];
                s1_port  <= attr[PORT_LSB +: N];
            end

            // The mux sees pre-update counters, so reads are read-before-write.
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;

            if (bus.clear_stats) begin
                unknown_cnt <= '0;
                for (int i = 0; i < N; i++) begin
                    pkt_cnt[i]  <= '0;
                    byte_cnt[i] <= '0;
                end
                for (int j = 0; j < P; j++) proto_cnt[j] <= '0;
            end else if (s1_valid) begin
                if (port_hit) begin
                    pkt_cnt[port_idx]  <= pkt_cnt[port_idx] + PKT_CNT_WIDTH'(1);
                    byte_cnt[port_idx] <= byte_cnt[port_idx] + BYTE_CNT_WIDTH'(s1_bytes);
                end else begin
                    unknown_cnt <= unknown_cnt + PKT_CNT_WIDTH'(1);
                end
                if (32'(s1_prtcl) < P) begin
                    proto_cnt[s1_prtcl] <= proto_cnt[s1_prtcl] + PKT_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule
